// File: rtl/vec_alu_pipe.sv
// Vector ALU with selectable element width, valid/ready handshake and shift-add multiplier.
// Define VALU_SAT_EN to enable saturating add on mode 7; otherwise mode 7 flags err.
module vec_alu_pipe #(
  parameter int unsigned LENGTH     = 32,
  parameter int unsigned SUB_LENGTH = 8,
  localparam int unsigned NChunk    = LENGTH / SUB_LENGTH,
  localparam int unsigned MaxLog    = $clog2(NChunk),
  localparam int unsigned ElenW     = $clog2(MaxLog + 1) + 1,
  localparam int unsigned CntW      = $clog2(LENGTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        mode,
  input  logic [ElenW-1:0]  elen,
  input  logic [LENGTH-1:0] op1,
  input  logic [LENGTH-1:0] op2,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out,
  output logic              carry,
  output logic              err
);

  typedef enum logic [2:0] {
    ModeAdd, ModeSub, ModeOr, ModeAnd, ModeNot, ModeXor, ModeMul, ModeSat
  } mode_e;

  typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

  // Element width is SUB_LENGTH << log, clamped so it never exceeds LENGTH.
  function automatic int unsigned elen_log(input logic [ElenW-1:0] e);
    return (32'(e) > MaxLog) ? MaxLog : 32'(e);
  endfunction

  function automatic logic [NChunk-1:0] chunk_starts(input logic [ElenW-1:0] e);
    logic [NChunk-1:0] m;
    int unsigned       span;
    span = 1 << elen_log(e);
    for (int unsigned k = 0; k < NChunk; k++) m[k] = ((k % span) == 0);
    return m;
  endfunction

  // Chunked ripple add/sub; the carry chain restarts at every element boundary.
  // Returns {carry/borrow out of the top element, sum}.
  function automatic logic [LENGTH:0] vadd(input logic [LENGTH-1:0] a,
                                           input logic [LENGTH-1:0] b,
                                           input logic              cin,
                                           input logic              sub,
                                           input logic [NChunk-1:0] starts);
    logic [LENGTH-1:0]   s;
    logic [SUB_LENGTH:0] t;
    logic                c;
    s = '0;
    c = 1'b0;
    for (int unsigned k = 0; k < NChunk; k++) begin
      if (starts[k]) c = (k == 0) ? cin : 1'b0;
      if (sub) begin
        t = {1'b0, a[k*SUB_LENGTH +: SUB_LENGTH]} - {1'b0, b[k*SUB_LENGTH +: SUB_LENGTH]}
            - {{SUB_LENGTH{1'b0}}, c};
      end else begin
        t = {1'b0, a[k*SUB_LENGTH +: SUB_LENGTH]} + {1'b0, b[k*SUB_LENGTH +: SUB_LENGTH]}
            + {{SUB_LENGTH{1'b0}}, c};
      end
      s[k*SUB_LENGTH +: SUB_LENGTH] = t[SUB_LENGTH-1:0];
      c = t[SUB_LENGTH];
    end
    return {c, s};
  endfunction

  state_e            state_q;
  logic [LENGTH-1:0] acc_q, mcand_q, mplier_q;
  logic [NChunk-1:0] start_q;
  logic [CntW-1:0]   cnt_q, w_q;

  logic [NChunk-1:0] start_in;
  logic [CntW-1:0]   w_in;
  logic [LENGTH:0]   arith_res;
  logic [LENGTH-1:0] res_out;
  logic              res_carry, res_err;

  assign in_ready = (state_q == StIdle) || ((state_q == StHold) && out_ready);

`ifdef VALU_SAT_EN
  logic [LENGTH-1:0]   sat_out;
  logic [NChunk-1:0]   sat_co;
  logic [NChunk:0]     sat_ends;
  logic [SUB_LENGTH:0] sat_t;
  logic                sat_any, sat_c, sat_f;

  // Per-element unsigned add; an element's carry-out floods that element with ones.
  always_comb begin
    sat_out  = '0;
    sat_co   = '0;
    sat_t    = '0;
    sat_c    = 1'b0;
    sat_f    = 1'b0;
    sat_any  = 1'b0;
    sat_ends = {1'b1, start_in};
    for (int unsigned k = 0; k < NChunk; k++) begin
      if (start_in[k]) sat_c = 1'b0;
      sat_t = {1'b0, op1[k*SUB_LENGTH +: SUB_LENGTH]} + {1'b0, op2[k*SUB_LENGTH +: SUB_LENGTH]}
              + {{SUB_LENGTH{1'b0}}, sat_c};
      sat_out[k*SUB_LENGTH +: SUB_LENGTH] = sat_t[SUB_LENGTH-1:0];
      sat_co[k] = sat_t[SUB_LENGTH];
      sat_c     = sat_t[SUB_LENGTH];
    end
    for (int k = int'(NChunk) - 1; k >= 0; k--) begin
      if (sat_ends[k+1]) begin
        sat_f   = sat_co[k];
        sat_any = sat_any | sat_f;
      end
      if (sat_f) sat_out[k*SUB_LENGTH +: SUB_LENGTH] = '1;
    end
  end
`endif

  always_comb begin
    start_in  = chunk_starts(elen);
    w_in      = CntW'(SUB_LENGTH << elen_log(elen));
    arith_res = vadd(op1, op2, carry_in, mode_e'(mode) == ModeSub, start_in);
    res_out   = '0;
    res_carry = 1'b0;
    res_err   = 1'b0;
    unique case (mode_e'(mode))
      ModeAdd, ModeSub: {res_carry, res_out} = arith_res;
      ModeOr:           res_out = op1 | op2;
      ModeAnd:          res_out = op1 & op2;
      ModeNot:          res_out = ~op1;
      ModeXor:          res_out = op1 ^ op2;
      ModeMul:          res_out = '0;
      ModeSat: begin
`ifdef VALU_SAT_EN
        res_out   = sat_out;
        res_carry = sat_any;
`else
        res_err   = 1'b1;
`endif
      end
      default:          res_out = '0;
    endcase
  end

  logic [NChunk:0]   starts_ext;
  logic [LENGTH-1:0] bit_start, bit_end, mul_sel, acc_next, mcand_next, mplier_next;
  logic              sel_cur;

  // One multiplier step: each element adds its multiplicand when its multiplier LSB is set,
  // then shifts stay confined to the element.
  always_comb begin
    starts_ext = {1'b1, start_q};
    bit_start  = '0;
    bit_end    = '0;
    mul_sel    = '0;
    sel_cur    = 1'b0;
    for (int unsigned i = 0; i < LENGTH; i++) begin
      bit_start[i] = start_q[i / SUB_LENGTH] && ((i % SUB_LENGTH) == 0);
      bit_end[i]   = starts_ext[i / SUB_LENGTH + 1] && ((i % SUB_LENGTH) == SUB_LENGTH - 1);
    end
    for (int unsigned i = 0; i < LENGTH; i++) begin
      if (bit_start[i]) sel_cur = mplier_q[i];
      mul_sel[i] = sel_cur;
    end
    acc_next    = LENGTH'(vadd(acc_q, mcand_q & mul_sel, 1'b0, 1'b0, start_q));
    mcand_next  = (mcand_q << 1) & ~bit_start;
    mplier_next = (mplier_q >> 1) & ~bit_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      out_valid <= 1'b0;
      out       <= '0;
      carry     <= 1'b0;
      err       <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      start_q   <= '0;
      cnt_q     <= '0;
      w_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle, StHold: begin
          if ((state_q == StHold) && out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
          end
          if (in_valid && in_ready) begin
            if (mode_e'(mode) == ModeMul) begin
              state_q   <= StExec;
              out_valid <= 1'b0;
              acc_q     <= '0;
              mcand_q   <= op1;
              mplier_q  <= op2;
              start_q   <= start_in;
              w_q       <= w_in;
              cnt_q     <= '0;
            end else begin
              state_q   <= StHold;
              out_valid <= 1'b1;
              out       <= res_out;
              carry     <= res_carry;
              err       <= res_err;
            end
          end
        end
        StExec: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_next;
          mplier_q <= mplier_next;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == w_q - CntW'(1)) begin
            state_q   <= StHold;
            out_valid <= 1'b1;
            out       <= acc_next;
            carry     <= 1'b0;
            err       <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Scoreboard bench for vec_alu_pipe: expected results queued at acceptance, checked on retire.
module tb_vec_alu_pipe;

  localparam logic [2:0] MAdd = 3'd0, MSub = 3'd1, MXor = 3'd5, MMul = 3'd6, MSat = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  mode, elen;
  logic [31:0] op1, op2, out;
  logic        carry_in, carry, err;

  logic [33:0] sb[$];
  logic [33:0] exp_m;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_retired = 0;

  always #5 clk = ~clk;

  vec_alu_pipe #(.LENGTH(32), .SUB_LENGTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .elen(elen), .op1(op1), .op2(op2), .carry_in(carry_in), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .carry(carry), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  // Reference model, element by element in wide integers. Returns {err, carry, out}.
  function automatic logic [33:0] model(input logic [2:0] m, input logic [2:0] e,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic ci);
    int unsigned     w;
    longint unsigned mask, x, y, r, cb;
    logic [31:0]     res;
    logic            c, er;
    w = 8 << e;
    if (w > 32) w = 32;
    mask = (64'd1 << w) - 64'd1;
    res = '0;
    c = 1'b0;
    er = 1'b0;
    case (m)
      3'd2: res = a | b;
      3'd3: res = a & b;
      3'd4: res = ~a;
      3'd5: res = a ^ b;
`ifndef VALU_SAT_EN
      3'd7: er = 1'b1;
`endif
      default: begin
        for (int unsigned el = 0; el < 32 / w; el++) begin
          x  = (64'(a) >> (el * w)) & mask;
          y  = (64'(b) >> (el * w)) & mask;
          cb = (el == 0) ? 64'(ci) : 64'd0;
          r  = 64'd0;
          case (m)
            3'd0: begin r = x + y + cb; c = ((r >> w) & 64'd1) != 0; end
            3'd1: begin r = x - y - cb; c = (x < y + cb); end
            3'd6: r = x * y;
            default: begin
              r = x + y;
              if (r > mask) begin r = mask; c = 1'b1; end
            end
          endcase
          res = res | 32'((r & mask) << (el * w));
        end
      end
    endcase
    return {er, c, res};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_m = sb.pop_front();
        check("out", 64'(out), 64'(exp_m[31:0]));
        check("carry", 64'(carry), 64'(exp_m[32]));
        check("err", 64'(err), 64'(exp_m[33]));
        n_retired++;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive(input logic [2:0] m, input logic [2:0] e, input logic [31:0] a,
                       input logic [31:0] b, input logic ci, input logic [33:0] expv,
                       output int waits);
    logic acc;
    mode = m; elen = e; op1 = a; op2 = b; carry_in = ci; in_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        sb.push_back(expv);
        break;
      end
      waits++;
      if (waits > 300) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
      #1 out_ready = 1'($urandom_range(0, 1));
    end
    #1;
    // Scramble inputs after acceptance; the DUT must have captured them.
    in_valid = 1'b0;
    mode = 3'($urandom); elen = 3'($urandom); op1 = $urandom; op2 = $urandom;
    carry_in = 1'($urandom);
  endtask

  task automatic send(input logic [2:0] m, input logic [2:0] e, input logic [31:0] a,
                      input logic [31:0] b, input logic ci, output int waits);
    drive(m, e, a, b, ci, model(m, e, a, b, ci), waits);
  endtask

  // Counts edges from the accepting edge (inclusive) until out_valid is seen.
  task automatic wait_valid(input bit chk_busy, output int edges);
    edges = 1;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      if (chk_busy) check("exec_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      edges++;
      if (edges > 100) begin
        check("valid_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int          waits, edges, base;
  logic [33:0] xv;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = '0; elen = '0;
    op1 = '0; op2 = '0; carry_in = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_carry", 64'(carry), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    drive(MAdd, 3'd0, 32'h01FF_80FF, 32'h0101_8001, 1'b1, {1'b0, 1'b0, 32'h0200_0001}, waits);
    wait_valid(1'b0, edges);
    check("add_latency", 64'(edges), 64'd1);

    drive(MSub, 3'd2, 32'h0, 32'h1, 1'b0, {1'b0, 1'b1, 32'hFFFF_FFFF}, waits);
    wait_valid(1'b0, edges);
    check("sub_latency", 64'(edges), 64'd1);

    drive(MMul, 3'd1, 32'h0003_0100, 32'h0005_0100, 1'b0, {1'b0, 1'b0, 32'h000F_0000}, waits);
    wait_valid(1'b1, edges);
    check("mul_latency", 64'(edges), 64'd17);

`ifdef VALU_SAT_EN
    drive(MSat, 3'd0, 32'h80FF_0001, 32'h80FF_0001, 1'b0, {1'b0, 1'b1, 32'hFFFF_0002}, waits);
`else
    drive(MSat, 3'd0, 32'h80FF_0001, 32'h80FF_0001, 1'b0, {1'b1, 1'b0, 32'h0}, waits);
`endif
    wait_valid(1'b0, edges);
    check("sat_latency", 64'(edges), 64'd1);

    // Back-to-back stream: every request must be taken without a wait cycle.
    base = n_retired;
    for (int i = 0; i < 8; i++) begin
      send(MXor, 3'($urandom), $urandom, $urandom, 1'b0, waits);
      check("stream_no_bubble", 64'(waits), 64'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    check("stream_retired", 64'(n_retired - base), 64'd8);

    // Output stall: result held stable and no new request taken.
    out_ready = 1'b0;
    xv = model(MXor, 3'd0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    send(MXor, 3'd0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, waits);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_out", 64'(out), 64'(xv[31:0]));
      check("stall_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Reset during multiplier execution.
    send(MMul, 3'd2, $urandom, $urandom, 1'b0, waits);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out", 64'(out), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(in_ready), 64'd1);
    check("post_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    send(MAdd, 3'd0, 32'h7F80_FFFF, 32'h0180_0001, 1'b1, waits);
    wait_valid(1'b0, edges);
    check("post_rst_add_latency", 64'(edges), 64'd1);

    // Random mix with random back-pressure.
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      send(3'($urandom), 3'($urandom), $urandom, $urandom, 1'($urandom), waits);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vec_alu_pipe.md
VEC_ALU_PIPE -- requirements
Module: vec_alu_pipe

Interface
REQ-001 SHALL have parameter LENGTH, default 32, total operand width in bits.
REQ-002 SHALL have parameter SUB_LENGTH, default 8, minimum element width in bits; LENGTH/SUB_LENGTH is a power of two.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, request accepted when in_valid and in_ready are both high at an edge.
REQ-007 SHALL have port mode, input, 3: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 NOT, 5 XOR, 6 MUL, 7 SATADD.
REQ-008 SHALL have port elen, input, $clog2($clog2(LENGTH/SUB_LENGTH)+1)+1; element width W = SUB_LENGTH<<elen.
REQ-009 SHALL have ports op1 and op2, input, LENGTH each; operands.
REQ-010 SHALL have port carry_in, input, 1; carry (ADD) or borrow (SUB) into element 0.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-013 SHALL have ports out (LENGTH), carry (1) and err (1), output, all registered.

Function
REQ-014 SHALL capture mode, elen, op1, op2 and carry_in on acceptance; later input changes have no effect.
REQ-015 SHALL clamp W to LENGTH when SUB_LENGTH<<elen exceeds LENGTH.
REQ-016 SHALL operate on LENGTH/W independent elements; no carry crosses element boundaries.
REQ-017 ADD: element 0 = a+b+carry_in, others a+b, each mod 2^W; carry = carry-out of the top element.
REQ-018 SUB: element 0 = a-b-carry_in, others a-b, each mod 2^W; carry = borrow-out of the top element.
REQ-019 OR/AND/XOR SHALL be bitwise on op1, op2; NOT = ~op1; carry = 0 for logic modes and MUL.
REQ-020 MUL SHALL produce the low W bits of the unsigned per-element product, via an iterative shift-add over exactly W cycles.
REQ-021 FSM states: IDLE, EXEC, HOLD; reset state IDLE.
REQ-022 IDLE: in_ready=1; on acceptance of MUL go EXEC, otherwise load the result and go HOLD.
REQ-023 EXEC: in_ready=0; perform one multiplier step per cycle; after the W-th step load the result and go HOLD.
REQ-024 HOLD: out_valid=1, with out, carry and err stable; if out_ready then leave HOLD.
REQ-025 in_ready SHALL also be 1 in HOLD while out_ready=1, so a new request is accepted in the same cycle the result retires (back-to-back, no bubble).
REQ-026 Latency from the acceptance edge: non-MUL, out_valid high after the next edge; MUL, out_valid high W+1 edges after acceptance.
REQ-027 Throughput: one non-MUL result per cycle when out_ready is held high.
REQ-028 out_valid=0 in IDLE and EXEC; out, carry and err hold their last values there.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, out_valid=0, out=0, carry=0, err=0 and clear multiplier state, including mid-EXEC.
REQ-030 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-031 Macro VALU_SAT_EN defined: SATADD (mode 7) SHALL give the per-element unsigned a+b clamped to 2^W-1, with err=0 and carry = 1 if any element saturated.
REQ-032 Macro VALU_SAT_EN undefined: mode 7 SHALL give out=0, carry=0, err=1, with normal handshake and 1-cycle latency; err=0 for all other modes in both builds.

Verification
REQ-033 ADD, elen=0, op1=0x01FF_80FF, op2=0x0101_8001, carry_in=1 -> out=0x0200_0001, carry=0, out_valid one cycle after accept.
REQ-034 SUB, elen=2, op1=0, op2=1, carry_in=0 -> out=0xFFFF_FFFF, carry=1.
REQ-035 MUL, elen=1, op1=0x0003_0100, op2=0x0005_0100 -> out=0x000F_0000; out_valid exactly 17 edges after accept; in_ready=0 throughout EXEC.
REQ-036 Back-to-back XOR stream with out_ready=1 -> one result per cycle; out_ready=0 for 3 cycles -> out stable and in_ready=0 until released.
REQ-037 rst_n pulsed low during MUL EXEC -> out_valid=0 and in_ready=1 after release; the next ADD completes correctly.
REQ-038 Mode 7, op1=op2=0x80FF_0001, elen=0 -> with VALU_SAT_EN: out=0xFFFF_0002, carry=1; without: out=0, err=1.
